wb_sram_test_master: RTL and testbench



---
 rtl/wb_sram_test_master.sv | 197 +++++++++++++++++++
 tb/tb_wb_sram_test_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_test_master.sv
// wb_sram_test_master
//   Wishbone classic initiator that exercises an SRAM slave with a self-checking
//   sweep over DEPTH words: write D(i), read-verify D(i), write ~D(i),
//   read-verify ~D(i), with D(i) = pattern ^ {4{i[7:0]}}.
//   Define WB_TEST_BYTE_LANE_EN to add a byte-lane write/verify pass (BL_W, BL_R)
//   after R1.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   start_i, pattern_i     start pulse (honoured in IDLE/DONE), base data pattern
//   wbm_*                  Wishbone master bus (cyc/stb/we/sel/adr/dat_o, dat_i/ack_i)
//   busy_o, done_o         test running / test finished (held until next start)
//   pass_o, timeout_o      result flags, valid with done_o
//   err_count_o            saturating read-mismatch count
//   first_err_idx_o        word index of first mismatch
module wb_sram_test_master #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          DEPTH     = 256,
    parameter int          TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] pattern_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_count_o,
    output logic [7:0]  first_err_idx_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef WB_TEST_BYTE_LANE_EN
    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, BL_W, BL_R, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;
`endif

    state_t        state_q, state_d, next_phase;
    logic          stb_q, stb_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [31:0]   pat_q, pat_d;
    logic [15:0]   err_q, err_d;
    logic [IW-1:0] first_q, first_d;
    logic          done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;

    logic [7:0]    idx8;
    logic [31:0]   d_val, wdata, expect_val;
    logic [3:0]    sel_v;
    logic          is_write, is_read;

    assign idx8  = 8'(idx_q);
    assign d_val = pat_q ^ {4{idx8}};

    // Per-phase data/lane selection and the phase that follows the current one.
    always_comb begin
        wdata      = d_val;
        expect_val = d_val;
        sel_v      = 4'hF;
        is_write   = 1'b0;
        is_read    = 1'b0;
        next_phase = DONE;
        case (state_q)
            W0: begin is_write = 1'b1; next_phase = R0; end
            R0: begin is_read = 1'b1; next_phase = W1; end
            W1: begin is_write = 1'b1; wdata = ~d_val; next_phase = R1; end
`ifdef WB_TEST_BYTE_LANE_EN
            R1: begin is_read = 1'b1; expect_val = ~d_val; next_phase = BL_W; end
            BL_W: begin
                is_write   = 1'b1;
                wdata      = {4{8'hA5}};
                sel_v      = 4'b0001 << idx8[1:0];
                next_phase = BL_R;
            end
            BL_R: begin
                is_read    = 1'b1;
                expect_val = ~d_val;
                expect_val[idx8[1:0]*8 +: 8] = 8'hA5;
            end
`else
            R1: begin is_read = 1'b1; expect_val = ~d_val; end
`endif
            default: ;
        endcase
    end

    // Bus outputs are only non-zero while the strobe is up.
    assign wbm_cyc_o = stb_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = stb_q & is_write;
    assign wbm_sel_o = stb_q ? sel_v : 4'h0;
    assign wbm_adr_o = stb_q ? (ADDR_BASE + (32'(idx8) << 2)) : 32'h0;
    assign wbm_dat_o = (stb_q && is_write) ? wdata : 32'h0;

    assign busy_o          = (state_q != IDLE) && (state_q != DONE);
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign timeout_o       = tmo_q;
    assign err_count_o     = err_q;
    assign first_err_idx_o = 8'(first_q);

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        pat_d   = pat_q;
        err_d   = err_q;
        first_d = first_q;
        done_d  = done_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = W0;
                    pat_d   = pattern_i;
                    idx_d   = '0;
                    stb_d   = 1'b0;
                    wait_d  = '0;
                    err_d   = '0;
                    first_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            default: begin
                if (!stb_q) begin
                    // The stb-low cycle here is the mandatory inter-transfer gap.
                    stb_d  = 1'b1;
                    wait_d = '0;
                end else if (wbm_ack_i) begin
                    stb_d = 1'b0;
                    if (is_read && (wbm_dat_i != expect_val)) begin
                        if (err_q == 16'h0) first_d = idx_q;
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'h1;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(DEPTH - 1)) begin
                        idx_d   = '0;
                        state_d = next_phase;
                        if (next_phase == DONE) begin
                            done_d = 1'b1;
                            pass_d = (err_d == 16'h0);
                        end
                    end
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    stb_d   = 1'b0;
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            idx_q   <= '0;
            wait_q  <= '0;
            pat_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
            first_q <= first_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_wb_sram_test_master.sv
// Directed bench for wb_sram_test_master (DEPTH=256, TIMEOUT=16) against a
// behavioural SRAM slave with configurable ack latency, no-ack mode and a
// stuck-at-0 fault on bit 3 of word 17.
module tb_wb_sram_test_master;
`ifdef WB_TEST_BYTE_LANE_EN
    localparam int PHASES  = 6;
    localparam int EXP_ERR = 2;  // R1 and BL_R both expect bit 3 of word 17 high
`else
    localparam int PHASES  = 4;
    localparam int EXP_ERR = 1;  // only R1 expects bit 3 of word 17 high
`endif
    localparam int RUN1 = PHASES * 256 * 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pattern = 32'h0;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    logic        busy, done, pass, tmo;
    logic [15:0] errc;
    logic [7:0]  first_idx;

    always #5 clk = ~clk;

    wb_sram_test_master dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .pattern_i(pattern),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat), .wbm_ack_i(ack),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
        .err_count_o(errc), .first_err_idx_o(first_idx)
    );

    // SRAM slave model: ack after ack_delay cycles of stb, write on that edge.
    logic [31:0] mem [256];
    int          acnt = 0;
    int          ack_delay = 1;
    bit          noack = 1'b0;
    bit          fault = 1'b0;
    logic [7:0]  wa;

    assign wa   = adr[9:2];
    assign rdat = (fault && wa == 8'd17) ? (mem[wa] & ~32'h8) : mem[wa];

    always @(posedge clk) begin
        if (rst || !(cyc && stb) || ack) begin
            ack  <= 1'b0;
            acnt <= 0;
        end else if (!noack) begin
            if (acnt + 1 >= ack_delay) begin
                ack <= 1'b1;
                if (we)
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) mem[wa][8*b +: 8] <= wdat[8*b +: 8];
            end
            acnt <= acnt + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run monitors
    int          cycles, first_len, cur_len, min_len, max_len, stable_bad;
    bit          first_end, w5_seen, bl_seen;
    logic [31:0] w5_dat, w5_adr, bl_dat, ref_adr, ref_dat;
    logic [3:0]  bl_sel, ref_sel;
    logic        ref_we;

    // Pulse start, then count edges from the accepting edge until done_o.
    task automatic run(input logic [31:0] pat, input int limit, input int mid_at);
        cycles = -1; first_len = 0; cur_len = 0; min_len = 100000; max_len = 0;
        stable_bad = 0; first_end = 0; w5_seen = 0; bl_seen = 0;
        w5_dat = 0; w5_adr = 0; bl_dat = 0; bl_sel = 0;
        @(posedge clk); #1 start = 1'b1; pattern = pat;
        while (cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
            start = (cycles == mid_at);
            if (stb) begin
                if (cur_len == 0) begin
                    ref_adr = adr; ref_dat = wdat; ref_we = we; ref_sel = sel;
                end else if (adr !== ref_adr || wdat !== ref_dat || we !== ref_we || sel !== ref_sel) begin
                    stable_bad++;
                end
                cur_len++;
                if (!first_end) first_len++;
                if (we && adr == 32'h3000_0014 && !w5_seen) begin
                    w5_seen = 1; w5_dat = wdat; w5_adr = adr;
                end
                if (we && sel != 4'hF && adr == 32'h3000_0018) begin
                    bl_seen = 1; bl_dat = wdat; bl_sel = sel;
                end
            end else if (cur_len > 0) begin
                if (cur_len < min_len) min_len = cur_len;
                if (cur_len > max_len) max_len = cur_len;
                cur_len = 0;
                first_end = 1;
            end
            if (done) break;
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(cyc), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(errc), 0);
        chk("rst_adr", adr, 0);
        rst = 1'b0;

        // 1: ideal 1-cycle-ack slave
        run(32'hDEADBEEF, 20000, -2);
        chk("t1_cycles", 32'(cycles), 32'(RUN1));
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_err", 32'(errc), 0);
        chk("t1_tmo", 32'(tmo), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_w5_seen", 32'(w5_seen), 1);
        chk("t1_w5_dat", w5_dat, 32'hDBA8BBEA);
        chk("t1_min_len", 32'(min_len), 2);
        chk("t1_max_len", 32'(max_len), 2);

        // 2: stuck-at-0 on bit 3 of word 17
        fault = 1'b1;
        run(32'h0, 20000, -2);
        chk("t2_done", 32'(done), 1);
        chk("t2_err", 32'(errc), 32'(EXP_ERR));
        chk("t2_first", 32'(first_idx), 17);
        chk("t2_pass", 32'(pass), 0);
        fault = 1'b0;

        // 3: ack delayed 5 cycles -> stb held 6 cycles with stable address/data
        ack_delay = 5;
        run(32'h5A5A_0F0F, 40000, -2);
        chk("t3_done", 32'(done), 1);
        chk("t3_min_len", 32'(min_len), 6);
        chk("t3_max_len", 32'(max_len), 6);
        chk("t3_stable", 32'(stable_bad), 0);
        chk("t3_pass", 32'(pass), 1);

        // 3b: ack on the last allowed wait cycle still completes
        ack_delay = 15;
        run(32'h0123_4567, 40000, -2);
        chk("t3b_len", 32'(max_len), 16);
        chk("t3b_tmo", 32'(tmo), 0);
        chk("t3b_pass", 32'(pass), 1);
        ack_delay = 1;

        // 4: slave never acks
        noack = 1'b1;
        run(32'hFFFF_0000, 100, -2);
        chk("t4_stb_len", 32'(first_len), 16);
        chk("t4_cycles", 32'(cycles), 17);
        chk("t4_done", 32'(done), 1);
        chk("t4_tmo", 32'(tmo), 1);
        chk("t4_pass", 32'(pass), 0);
        chk("t4_cyc", 32'(cyc), 0);
        noack = 1'b0;

        // 5: reset mid-R0, then a fresh run with a stray start while busy
        @(posedge clk); #1 start = 1'b1; pattern = 32'h1234_5678;
        @(posedge clk); #1 start = 1'b0;
        repeat (901) @(posedge clk);
        #1;
        chk("t5_pre_stb", 32'(stb), 1);
        chk("t5_pre_we", 32'(we), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_cyc", 32'(cyc), 0);
        chk("t5_rst_stb", 32'(stb), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_done", 32'(done), 0);
        rst = 1'b0;
        run(32'hCAFE_F00D, 20000, 100);
        chk("t5_cycles", 32'(cycles), 32'(RUN1));
        chk("t5_pass", 32'(pass), 1);
        chk("t5_err", 32'(errc), 0);

        // 6: byte-lane pass, pattern 0
        run(32'h0, 20000, -2);
        chk("t6_pass", 32'(pass), 1);
`ifdef WB_TEST_BYTE_LANE_EN
        chk("t6_bl_seen", 32'(bl_seen), 1);
        chk("t6_bl_sel", 32'(bl_sel), 32'h4);
        chk("t6_bl_dat", bl_dat, 32'hA5A5A5A5);
        chk("t6_mem6", mem[6], 32'hF9A5F9F9);
`else
        chk("t6_no_bl", 32'(bl_seen), 0);
        chk("t6_mem6", mem[6], 32'hF9F9F9F9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
